// File: rtl/noc_pkg.sv
// Shared router definitions: packet width, header field positions, port indices
// and the packed header layout used by the ingress demux and output merge.
package noc_pkg;

    localparam int WIDTH_packet = 57;
    localparam int DST_MSB      = 56;
    localparam int HOP_MSB      = 54;
    localparam int PAYLOAD_W    = 51;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;
    localparam int PORT2 = 2;
    localparam int PORT3 = 3;

    typedef struct packed {
        logic [1:0]           dst;
        logic [3:0]           hop;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_hdr_t;

endpackage

// File: rtl/input_ctrl_demux_if.sv
// Ingress packet handshake plus the four per-output FIFO heads and drop counter.
// The master side is the upstream source and downstream sinks; the demux is the slave.
interface input_ctrl_demux_if;
    import noc_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH_packet-1:0] in_data;
    logic [3:0]              out_valid;
    logic [3:0]              out_ready;
    logic [WIDTH_packet-1:0] out_data0;
    logic [WIDTH_packet-1:0] out_data1;
    logic [WIDTH_packet-1:0] out_data2;
    logic [WIDTH_packet-1:0] out_data3;
    logic [15:0]             drop_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, drop_cnt
    );

endinterface

// File: rtl/pkt_fifo.sv
// Small synchronous FIFO holding whole packets; the head is always visible on dout.
// Storage is cleared on reset so an empty FIFO presents all-zero data.
module pkt_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide so they wrap without explicit compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/input_ctrl_demux.sv
// Router ingress: decodes destination and hop count, drops expired packets,
// decrements the hop field and steers each packet into one of four output FIFOs.
module input_ctrl_demux
    import noc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input_ctrl_demux_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [1:0]              dst;
    logic [3:0]              hop;
    logic                    drop;
    logic                    in_ready_int;
    logic                    accept;
    logic [WIDTH_packet-1:0] wr_pkt;
    logic [3:0]              push;
    logic [3:0]              pop;
    logic [3:0]              empty;
    logic [3:0]              full;
    logic [WIDTH_packet-1:0] fifo_dout  [4];
    logic [AW:0]             fifo_count [4];

    assign dst  = bus.in_data[DST_MSB -: 2];
    assign hop  = bus.in_data[HOP_MSB -: 4];
    assign drop = (hop == 4'd0);

    // Only the registered count gates acceptance; a same-cycle pop never frees a slot.
    assign in_ready_int = drop || (fifo_count[dst] < DEPTH_C);
    assign accept       = bus.in_valid && in_ready_int;
    assign bus.in_ready = in_ready_int;

    always_comb begin
        wr_pkt                 = bus.in_data;
        wr_pkt[HOP_MSB -: 4]   = hop - 4'd1;
        push                   = 4'b0000;
        if (accept && !drop) begin
            push[dst] = 1'b1;
        end
    end

    assign pop = bus.out_ready & ~empty;

    for (genvar k = 0; k < 4; k++) begin : g_fifo
        pkt_fifo #(
            .WIDTH (WIDTH_packet),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (wr_pkt),
            .dout  (fifo_dout[k]),
            .count (fifo_count[k]),
            .empty (empty[k]),
            .full  (full[k])
        );

        a_no_push_when_full: assert property (
            @(posedge clk) disable iff (!rst_n) !(push[k] && full[k])
        );
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data0 = fifo_dout[PORT0];
    assign bus.out_data1 = fifo_dout[PORT1];
    assign bus.out_data2 = fifo_dout[PORT2];
    assign bus.out_data3 = fifo_dout[PORT3];

    // Expired packets are consumed without a FIFO write; the counter sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.drop_cnt <= 16'd0;
        end else if (accept && drop && (bus.drop_cnt != 16'hFFFF)) begin
            bus.drop_cnt <= bus.drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_input_ctrl_demux.sv
// Directed testbench for the router ingress demux: reset, hop rewrite, backpressure,
// drops, head-of-line blocking, full-rate streaming and mid-operation reset.
module tb_input_ctrl_demux;
    import noc_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    input_ctrl_demux_if bus ();

    input_ctrl_demux #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WIDTH_packet-1:0] make_pkt(input logic [1:0] d, input logic [3:0] h,
                                                         input logic [PAYLOAD_W-1:0] p);
        pkt_hdr_t x;
        x.dst     = d;
        x.hop     = h;
        x.payload = p;
        return x;
    endfunction

    function automatic logic [WIDTH_packet-1:0] out_sel(input int k);
        case (k)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        step();
        step();
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL reset_valid: got %b want 0000", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.drop_cnt !== 16'd0) $display("[TB] FAIL reset_drop: got %0d want 0", bus.drop_cnt);
        else pass_cnt++;
        total_cnt++;
        if ((bus.out_data0 | bus.out_data1 | bus.out_data2 | bus.out_data3) !== '0)
            $display("[TB] FAIL reset_data: got nonzero head want 0");
        else pass_cnt++;
        rst_n = 1'b1;
        bus.in_data = make_pkt(2'd1, 4'd7, 51'h5);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        step();
    endtask

    task automatic test_basic();
        bus.in_valid = 1'b1;
        bus.in_data  = make_pkt(2'd2, 4'd5, 51'h1234);
        step();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 4'b0100) $display("[TB] FAIL basic_valid: got %b want 0100", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data2 !== make_pkt(2'd2, 4'd4, 51'h1234))
            $display("[TB] FAIL basic_data: got %h want %h", bus.out_data2, make_pkt(2'd2, 4'd4, 51'h1234));
        else pass_cnt++;
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL basic_drain: got %b want 0000", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1'b1;
        bus.in_data  = make_pkt(2'd1, 4'd3, 51'd1);
        step();
        bus.in_data  = make_pkt(2'd1, 4'd3, 51'd2);
        step();
        bus.in_data  = make_pkt(2'd1, 4'd3, 51'd3);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_full_ready: got %b want 0", bus.in_ready);
        else pass_cnt++;
        bus.out_ready = 4'b0010;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_no_passthru: got %b want 0", bus.in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.out_data1 !== make_pkt(2'd1, 4'd2, 51'd2))
            $display("[TB] FAIL bp_order2: got %h want %h", bus.out_data1, make_pkt(2'd1, 4'd2, 51'd2));
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_pop: got %b want 1", bus.in_ready);
        else pass_cnt++;
        step();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_data1 !== make_pkt(2'd1, 4'd2, 51'd3) || bus.out_valid !== 4'b0010)
            $display("[TB] FAIL bp_order3: got %h/%b want %h/0010", bus.out_data1, bus.out_valid,
                     make_pkt(2'd1, 4'd2, 51'd3));
        else pass_cnt++;
        step();
        bus.out_ready = 4'b0000;
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL bp_drain: got %b want 0000", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_drop();
        int not_ready = 0;
        for (int d = 0; d < 4; d++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = make_pkt(d[1:0], 4'd0, 51'(d + 100));
            #1;
            if (bus.in_ready !== 1'b1) not_ready++;
            step();
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (not_ready != 0) $display("[TB] FAIL drop_ready: got %0d stalls want 0", not_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL drop_valid: got %b want 0000", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.drop_cnt !== 16'd4) $display("[TB] FAIL drop_cnt: got %0d want 4", bus.drop_cnt);
        else pass_cnt++;
    endtask

    task automatic test_hol();
        bus.in_valid = 1'b1;
        bus.in_data  = make_pkt(2'd1, 4'd2, 51'hA);
        step();
        bus.in_data  = make_pkt(2'd1, 4'd2, 51'hB);
        step();
        bus.in_data  = make_pkt(2'd1, 4'd2, 51'hC);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("[TB] FAIL hol_ready: got %b want 0", bus.in_ready);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (bus.out_valid !== 4'b0010) $display("[TB] FAIL hol_blocked: got %b want 0010", bus.out_valid);
        else pass_cnt++;
        bus.out_ready = 4'b0010;
        step();
        bus.out_ready = 4'b0000;
        step();
        bus.in_data  = make_pkt(2'd3, 4'd8, 51'hD);
        step();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 4'b1010) $display("[TB] FAIL hol_release: got %b want 1010", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data3 !== make_pkt(2'd3, 4'd7, 51'hD) || bus.out_data1 !== make_pkt(2'd1, 4'd1, 51'hB))
            $display("[TB] FAIL hol_data: got %h/%h want %h/%h", bus.out_data3, bus.out_data1,
                     make_pkt(2'd3, 4'd7, 51'hD), make_pkt(2'd1, 4'd1, 51'hB));
        else pass_cnt++;
        bus.out_ready = 4'b1010;
        step();
        step();
        bus.out_ready = 4'b0000;
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL hol_drain: got %b want 0000", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH_packet-1:0] exp_pkt;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = make_pkt(i[1:0], 4'd9, 51'(i + 16'h200));
            #1;
            total_cnt++;
            if (bus.in_ready !== 1'b1) $display("[TB] FAIL stream_ready%0d: got %b want 1", i, bus.in_ready);
            else pass_cnt++;
            step();
            exp_pkt = make_pkt(i[1:0], 4'd8, 51'(i + 16'h200));
            total_cnt++;
            if (bus.out_valid !== (4'b0001 << i[1:0]) || out_sel(i % 4) !== exp_pkt)
                $display("[TB] FAIL stream_out%0d: got %b/%h want %b/%h", i, bus.out_valid,
                         out_sel(i % 4), 4'b0001 << i[1:0], exp_pkt);
            else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'b0000;
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL stream_drain: got %b want 0000", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_data  = make_pkt(2'd0, 4'd4, 51'h31);
        step();
        bus.in_data  = make_pkt(2'd0, 4'd4, 51'h32);
        step();
        bus.in_data  = make_pkt(2'd2, 4'd4, 51'h33);
        step();
        total_cnt++;
        if (bus.out_valid !== 4'b0101) $display("[TB] FAIL mid_fill: got %b want 0101", bus.out_valid);
        else pass_cnt++;
        bus.in_data = make_pkt(2'd2, 4'd4, 51'h34);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 4'b0000 || bus.drop_cnt !== 16'd0)
            $display("[TB] FAIL mid_async: got %b/%0d want 0000/0", bus.out_valid, bus.drop_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.out_valid !== 4'b0000) $display("[TB] FAIL mid_no_xfer: got %b want 0000", bus.out_valid);
        else pass_cnt++;
        rst_n = 1'b1;
        bus.in_data = make_pkt(2'd2, 4'd6, 51'h77);
        step();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 4'b0100 || bus.out_data2 !== make_pkt(2'd2, 4'd5, 51'h77))
            $display("[TB] FAIL mid_first_out: got %b/%h want 0100/%h", bus.out_valid, bus.out_data2,
                     make_pkt(2'd2, 4'd5, 51'h77));
        else pass_cnt++;
    endtask

    initial begin
        $display("[TB] starting input_ctrl_demux tests");
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_hol();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/input_ctrl_demux.md
Name: input_ctrl_demux

Overview:
- Ingress half of the router port; mirror of the 4:1 output merge.
- Accepts one 57-bit packet stream over a clocked valid/ready handshake and decodes the 2-bit destination field.
- Decrements the hop count and steers each packet into one of four per-output FIFOs, which present packets to the four downstream merge inputs.
- Packets that arrive with an expired hop count are dropped and counted.

Parameters:
- WIDTH_packet, 57, packet width in bits.
- DEPTH, 2, entries per output FIFO; must be a power of two and at least 2.
- DST_MSB, 56, MSB of the 2-bit destination field, so dst = pkt[DST_MSB:DST_MSB-1].
- HOP_MSB, 54, MSB of the 4-bit hop-count field, so hop = pkt[HOP_MSB:HOP_MSB-3].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream packet valid.
- in_ready  output  1  block can accept the presented packet.
- in_data  input  WIDTH_packet  upstream packet.
- out_valid  output  4  per-output FIFO non-empty.
- out_ready  input  4  per-output downstream accept.
- out_data0  output  WIDTH_packet  head of FIFO 0.
- out_data1  output  WIDTH_packet  head of FIFO 1.
- out_data2  output  WIDTH_packet  head of FIFO 2.
- out_data3  output  WIDTH_packet  head of FIFO 3.
- drop_cnt  output  16  count of dropped packets.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid = 4'b0000.
  - out_data0..3 = 0.
  - drop_cnt = 0.
  - All FIFO pointers and counts = 0.
  - in_ready stays combinational; it equals 1 during reset release because all FIFOs are empty.
- Input handshake:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
- Decode, combinational on in_data:
  - dst = 2-bit destination field.
  - hop = 4-bit hop field.
  - drop = (hop == 0).
- in_ready:
  - 1 when drop = 1.
  - Otherwise 1 when count[dst] < DEPTH.
  - A same-cycle pop does not free space: in_ready uses the registered count only, with no pass-through when full.
- Accept, non-drop:
  - Write in_data into FIFO[dst], with the hop field replaced by hop-1 and all other bits unchanged.
  - count[dst] increments unless that FIFO pops in the same cycle; if it does, count is unchanged.
- Accept, drop:
  - No FIFO write.
  - drop_cnt increments, saturating at 16'hFFFF.
- Latency:
  - A packet accepted at edge N appears on out_valid[dst] / out_dataN after edge N, i.e. one cycle.
  - A packet cannot leave in the same cycle it is accepted.
- Output handshake, per port k, independent of the other ports:
  - A pop occurs on an edge where out_valid[k] && out_ready[k].
  - out_data_k always shows the FIFO head; its contents are don't-care when empty.
  - Order is preserved per output (FIFO).
  - No ordering is guaranteed across outputs.
- Head-of-line blocking: a full target FIFO stalls the input, even if other FIFOs have space.
- Wrap-around: read and write pointers are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits wide.
- Simultaneous events:
  - Push and pop on the same FIFO in the same edge is legal whenever count < DEPTH.
  - Pops on all four outputs plus one push in a single cycle is legal.
- Reset mid-operation:
  - Asserting rst_n low immediately flushes all FIFOs and clears drop_cnt.
  - Packets in flight are lost.
  - The upstream transfer in that cycle does not happen.
- No state machine beyond the FIFO counters; the block is fully pipelined at one packet per cycle when unblocked.

Decomposition:
- Shared package noc_pkg:
  - WIDTH_packet.
  - Field position constants DST_MSB and HOP_MSB.
  - Port index constants PORT0..PORT3.
  - A packed struct typedef for the packet header.
- Sub-module pkt_fifo:
  - Parameterised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout, count, empty, full.
  - Instantiated four times.
- Decode, in_ready, hop rewrite and drop_cnt stay in the top level.

Test Plan:
- Reset, then send dst=2, hop=5, payload 0x1234 -> after 1 cycle out_valid=4'b0100; out_data2 hop field=4 and payload 0x1234; other bits unchanged.
- out_ready=0, send three packets with dst=1, hop=3 -> first two accepted; in_ready=0 on the third; set out_ready[1]=1 -> third accepted one cycle after the first pop; order is 1, 2, 3.
- Send hop=0 packets to dst 0..3 -> in_ready stays 1; no out_valid rises; drop_cnt=4.
- With FIFO1 full, present a dst=1 packet then a dst=3 packet -> dst=3 packet does not pass until FIFO1 pops (HOL blocking verified).
- Stream 16 packets round-robin over dst 0..3, all out_ready=1 -> one accept per cycle; each output receives 4 in order; hop decremented by 1 on each.
- Fill FIFO0 and FIFO2, then drive rst_n low mid-stream -> out_valid=0 asynchronously; drop_cnt=0; after release the next packet emerges first on its output.
